// File: rtl/cpu_pkg.sv
// Shared CPU constants: widths, the NOP encoding, instruction field positions and
// the fetch-stage action decode.
package cpu_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned INST_W = 32;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int unsigned OPCODE_HI = 31;
  localparam int unsigned OPCODE_LO = 26;
  localparam int unsigned IMM_HI    = 25;
  localparam int unsigned IMM_LO    = 10;
  localparam int unsigned RS_HI     = 9;
  localparam int unsigned RS_LO     = 5;
  localparam int unsigned RD_HI     = 4;
  localparam int unsigned RD_LO     = 0;

  typedef enum logic [1:0] {
    FetchNormal,
    FetchStall,
    FetchRedirect
  } fetch_op_e;

  function automatic logic [5:0] get_opcode(input logic [31:0] inst);
    return inst[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or flush it to a bubble.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned INST_W = cpu_pkg::INST_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic [INST_W-1:0] i_inst,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_valid
);

  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_next;
  logic              r_valid;
  logic [ADDR_W-1:0] w_pc_inc;

  // Natural ADDR_W overflow gives the required wrap to zero.
  assign w_pc_inc = i_pc + ADDR_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_inst    <= INST_W'(NOP);
      r_pc      <= '0;
      r_pc_next <= ADDR_W'(1);
      r_valid   <= 1'b0;
    end else if (i_flush) begin
      r_inst    <= INST_W'(NOP);
      r_pc      <= i_pc;
      r_pc_next <= w_pc_inc;
      r_valid   <= 1'b0;
    end else if (i_load) begin
      r_inst    <= i_inst;
      r_pc      <= i_pc;
      r_pc_next <= w_pc_inc;
      r_valid   <= 1'b1;
    end
  end

  assign o_inst    = r_inst;
  assign o_pc      = r_pc;
  assign o_pc_next = r_pc_next;
  assign o_valid   = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register and next-PC mux, IF/ID register, and a
// saturating count of instructions accepted into IF/ID.
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned       INST_W   = cpu_pkg::INST_W,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_br_taken,
  input  logic [ADDR_W-1:0] i_br_target,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [INST_W-1:0] i_rom_inst,
  output logic [INST_W-1:0] o_id_inst,
  output logic [ADDR_W-1:0] o_id_pc,
  output logic [ADDR_W-1:0] o_id_pc_next,
  output logic              o_id_valid,
  output logic [CNT_W-1:0]  o_fetch_cnt
);

  fetch_op_e         w_op;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_d;

  // Redirect outranks stall so a taken branch is never lost behind a hazard.
  always_comb begin
    w_op = FetchNormal;
    if (i_br_taken) begin
      w_op = FetchRedirect;
    end else if (i_stall) begin
      w_op = FetchStall;
    end
  end

  always_comb begin
    w_pc_d  = r_pc;
    w_cnt_d = r_cnt;
    unique case (w_op)
      FetchRedirect: w_pc_d = i_br_target;
      FetchStall:    w_pc_d = r_pc;
      FetchNormal: begin
        w_pc_d = r_pc + ADDR_W'(1);
        if (r_cnt != '1) begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      default:       w_pc_d = r_pc;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc  <= RESET_PC;
      r_cnt <= '0;
    end else begin
      r_pc  <= w_pc_d;
      r_cnt <= w_cnt_d;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_if_id_reg (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_op == FetchNormal),
    .i_flush   (w_op == FetchRedirect),
    .i_inst    (i_rom_inst),
    .i_pc      (r_pc),
    .o_inst    (o_id_inst),
    .o_pc      (o_id_pc),
    .o_pc_next (o_id_pc_next),
    .o_valid   (o_id_valid)
  );

  assign o_rom_addr  = r_pc;
  assign o_fetch_cnt = r_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small combinational ROM model.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [5:0]  br_target;
  logic [5:0]  rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_inst;
  logic [5:0]  id_pc;
  logic [5:0]  id_pc_next;
  logic        id_valid;
  logic [15:0] fetch_cnt;

  logic [31:0] rom [64];

  int n_checks = 0;
  int n_pass   = 0;

  if_stage u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stall      (stall),
    .i_br_taken   (br_taken),
    .i_br_target  (br_target),
    .o_rom_addr   (rom_addr),
    .i_rom_inst   (rom_inst),
    .o_id_inst    (id_inst),
    .o_id_pc      (id_pc),
    .o_id_pc_next (id_pc_next),
    .o_id_valid   (id_valid),
    .o_fetch_cnt  (fetch_cnt)
  );

  assign rom_inst = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hC000_0000 | i;
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h3000_1043;
    rom[2] = 32'h0010_1041;
    rom[3] = 32'h3400_1045;
    rom[4] = 32'h0821_1807;

    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    step();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_valid", id_valid, 0);
    check("rst_inst", id_inst, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_pc_next", id_pc_next, 1);
    check("rst_cnt", fetch_cnt, 0);

    rst_n = 1'b1;
    step();
    check("e1_valid", id_valid, 1);
    check("e1_inst", id_inst, 32'h0000_0000);
    check("e1_id_pc", id_pc, 0);
    step();
    check("e2_inst", id_inst, 32'h3000_1043);
    check("e2_id_pc", id_pc, 1);
    check("e2_id_pc_next", id_pc_next, 2);
    step();
    check("e3_cnt", fetch_cnt, 3);
    check("e3_rom_addr", rom_addr, 3);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_inst", id_inst, 32'h0010_1041);
      check("stall_id_pc", id_pc, 2);
      check("stall_rom_addr", rom_addr, 3);
      check("stall_cnt", fetch_cnt, 3);
    end
    stall = 1'b0;
    step();
    check("unstall_inst", id_inst, 32'h3400_1045);
    check("unstall_id_pc", id_pc, 3);
    check("unstall_cnt", fetch_cnt, 4);

    check("pre_br_pc", rom_addr, 4);
    br_taken = 1'b1; br_target = 6'd1;
    step();
    check("br_valid", id_valid, 0);
    check("br_inst", id_inst, 0);
    check("br_pc", rom_addr, 1);
    check("br_id_pc", id_pc, 4);
    check("br_cnt", fetch_cnt, 4);
    br_taken = 1'b0;
    step();
    check("tgt_inst", id_inst, 32'h3000_1043);
    check("tgt_id_pc", id_pc, 1);
    check("tgt_valid", id_valid, 1);
    check("tgt_cnt", fetch_cnt, 5);

    stall = 1'b1; br_taken = 1'b1; br_target = 6'd0;
    step();
    check("brst_pc", rom_addr, 0);
    check("brst_valid", id_valid, 0);
    check("brst_cnt", fetch_cnt, 5);

    stall = 1'b0; br_target = 6'd5;
    step();
    br_target = 6'd2;
    step();
    check("b2b_pc", rom_addr, 2);
    check("b2b_valid", id_valid, 0);
    br_taken = 1'b0;
    step();
    check("b2b_inst", id_inst, 32'h0010_1041);
    check("b2b_id_pc", id_pc, 2);
    check("b2b_cnt", fetch_cnt, 6);

    for (int i = 0; i < 100 && rom_addr != 6'd63; i++) step();
    check("reach_pc63", rom_addr, 63);
    step();
    check("wrap_pc", rom_addr, 0);
    check("wrap_id_pc", id_pc, 63);
    check("wrap_id_pc_next", id_pc_next, 0);
    check("wrap_inst", id_inst, 32'hC000_003F);

    stall = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    check("rst_stall_pc", rom_addr, 0);
    check("rst_stall_valid", id_valid, 0);
    check("rst_stall_cnt", fetch_cnt, 0);
    check("rst_stall_inst", id_inst, 0);
    rst_n = 1'b1; stall = 1'b0;
    step();
    check("post_rst_id_pc", id_pc, 0);
    check("post_rst_pc", rom_addr, 1);
    check("post_rst_valid", id_valid, 1);
    check("post_rst_cnt", fetch_cnt, 1);

    for (int i = 0; i < 65534; i++) step();
    check("cnt_max", fetch_cnt, 16'hFFFF);
    step();
    check("cnt_sat", fetch_cnt, 16'hFFFF);
    check("cnt_sat_valid", id_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
